// File: rtl/mseq_pkg.sv
// mseq_pkg: shared types and constants for the maximal-sequence generator.
//   mode_e       - LFSR feedback structure (Fibonacci or Galois)
//   TAPS_FIB_W4  - reset tap mask used by mseq_gen (x^4 + x^3 + 1, Fibonacci form)
//   TAPS_GAL_Wn  - maximal-length Galois (right-shift) tap masks for common widths
package mseq_pkg;

    typedef enum logic {
        MODE_FIB = 1'b0,
        MODE_GAL = 1'b1
    } mode_e;

    localparam logic [3:0]  TAPS_FIB_W4  = 4'b0011;
    localparam logic [3:0]  TAPS_GAL_W4  = 4'b1100;
    localparam logic [7:0]  TAPS_GAL_W8  = 8'hB8;
    localparam logic [15:0] TAPS_GAL_W16 = 16'hB400;
    localparam logic [31:0] TAPS_GAL_W32 = 32'hD000_0001;

endpackage

// File: rtl/mseq_step.sv
// mseq_step: purely combinational single-step next-state logic of the LFSR.
//   state   - current LFSR register
//   taps    - feedback tap mask
//   mode    - MODE_FIB: shift right, new MSB = XOR of tapped bits
//             MODE_GAL: shift right, XOR taps in when the outgoing bit is 1
//   next    - LFSR value after one step
//   out_bit - bit shifted out by this step (pre-step state[0])
module mseq_step
    import mseq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next,
    output logic             out_bit
);

    logic fb;

    always_comb begin
        fb      = ^(state & taps);
        out_bit = state[0];
        next    = '0;
        unique case (mode)
            MODE_FIB: next = {fb, state[WIDTH-1:1]};
            MODE_GAL: next = (state >> 1) ^ (state[0] ? taps : '0);
            default:  next = '0;
        endcase
    end

endmodule

// File: rtl/mseq_gen.sv
// mseq_gen: configurable LFSR sequence generator with step divider and
// period detection. All registers live here; the step function is in mseq_step.
//   clk, rst      - clock, asynchronous active-high reset
//   cfg_load      - strobe capturing cfg_taps/cfg_seed/cfg_mode/cfg_div and
//                   restarting the sequence from the new seed
//   en            - run enable; a step happens every div+1 enabled cycles
//   state         - current LFSR register
//   bit_out       - bit shifted out by the most recent step
//   bit_valid     - one-cycle pulse aligned with each new state
//   period_done   - one-cycle pulse when a step returned the state to the seed
//   period_len    - step count of the last completed period
//   lockup        - state is all zeros
module mseq_gen
    import mseq_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter int unsigned     DIV_W    = 8,
    parameter logic [WIDTH-1:0] RST_TAPS = TAPS_FIB_W4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             en,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             period_done,
    output logic [WIDTH:0]   period_len,
    output logic             lockup
);

    logic [WIDTH-1:0] taps_r;
    logic [WIDTH-1:0] seed_r;
    mode_e            mode_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] divcnt;
    logic [WIDTH-1:0] state_r;
    logic [WIDTH:0]   step_cnt;
    logic [WIDTH:0]   period_len_r;
    logic             bit_out_r;
    logic             bit_valid_r;
    logic             period_done_r;

    logic [WIDTH-1:0] next_state;
    logic             step_bit;
    logic [WIDTH:0]   step_inc;
    logic             returned;

    mseq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state   (state_r),
        .taps    (taps_r),
        .mode    (mode_r),
        .next    (next_state),
        .out_bit (step_bit)
    );

    // Saturating increment: a sequence that never returns must not wrap
    // the counter into a bogus period length.
    assign step_inc = (step_cnt == '1) ? step_cnt : step_cnt + (WIDTH+1)'(1);

    // A zero state trivially "returns" to a zero seed on every step; that is
    // lockup, not a period, so it never reports period_done.
    assign returned = (next_state == seed_r) && (state_r != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_r        <= RST_TAPS;
            seed_r        <= WIDTH'(1);
            mode_r        <= MODE_FIB;
            div_r         <= '0;
            divcnt        <= '0;
            state_r       <= WIDTH'(1);
            step_cnt      <= '0;
            period_len_r  <= '0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            period_done_r <= 1'b0;
        end else if (cfg_load) begin
            taps_r        <= cfg_taps;
            seed_r        <= cfg_seed;
            mode_r        <= mode_e'(cfg_mode);
            div_r         <= cfg_div;
            state_r       <= cfg_seed;
            divcnt        <= '0;
            step_cnt      <= '0;
            bit_valid_r   <= 1'b0;
            period_done_r <= 1'b0;
        end else begin
            bit_valid_r   <= 1'b0;
            period_done_r <= 1'b0;
            if (en) begin
                if (divcnt != div_r) begin
                    divcnt <= divcnt + DIV_W'(1);
                end else begin
                    divcnt      <= '0;
                    state_r     <= next_state;
                    bit_out_r   <= step_bit;
                    bit_valid_r <= 1'b1;
                    if (returned) begin
                        period_done_r <= 1'b1;
                        period_len_r  <= step_inc;
                        step_cnt      <= '0;
                    end else begin
                        step_cnt <= step_inc;
                    end
                end
            end
        end
    end

    assign state       = state_r;
    assign bit_out     = bit_out_r;
    assign bit_valid   = bit_valid_r;
    assign period_done = period_done_r;
    assign period_len  = period_len_r;
    assign lockup      = (state_r == '0);

endmodule
